// File: rtl/sr_pkg.sv
// Shared types and helpers for the SR flip-flop bank driver.
// sr_excite is the excitation encoder: it maps the target and current q to set/reset masks.
package sr_pkg;

  localparam int SR_MAX_W             = 64;
  localparam int SR_PULSE_CYCLES_DEF  = 2;
  localparam int SR_SETTLE_CYCLES_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_PULSE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4
  } sr_drv_state_t;

  // Returns {set_mask, rst_mask}; an unknown q bit never counts as already correct.
  function automatic logic [2*SR_MAX_W-1:0] sr_excite(input logic [SR_MAX_W-1:0] target,
                                                      input logic [SR_MAX_W-1:0] q);
    logic [SR_MAX_W-1:0] set_mask;
    logic [SR_MAX_W-1:0] rst_mask;
    for (int i = 0; i < SR_MAX_W; i++) begin
      set_mask[i] = target[i] & (q[i] !== 1'b1);
      rst_mask[i] = ~target[i] & (q[i] !== 1'b0);
    end
    return {set_mask, rst_mask};
  endfunction

endpackage

// File: rtl/sr_bank_driver_if.sv
// Target handshake and transaction status between control logic and the SR bank driver.
interface sr_bank_driver_if #(
  parameter int WIDTH = 8,
  parameter int RW    = 2
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic             busy;
  logic             done;
  logic             err;
  logic [RW-1:0]    retries;

  modport master (output tgt_valid, tgt_data, input tgt_ready, busy, done, err, retries);
  modport slave  (input tgt_valid, tgt_data, output tgt_ready, busy, done, err, retries);
endinterface

// File: rtl/sr_phase_timer.sv
// Loadable down-counter timing the PULSE and SETTLE phases; tc is high while the count is zero.
module sr_phase_timer #(
  parameter int MAX_CNT = 2,
  parameter int CW      = $clog2(MAX_CNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);
  logic [CW-1:0] cnt_r;

  // Count down to zero and park there until reloaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == {CW{1'b0}});
endmodule

// File: rtl/sr_bank_driver.sv
// Drives set/reset excitation into an SR flip-flop bank until readback matches the target,
// retrying a bounded number of times; set and reset masks are disjoint by construction.
module sr_bank_driver
  import sr_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int PULSE_CYCLES  = SR_PULSE_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SR_SETTLE_CYCLES_DEF,
  parameter int MAX_RETRY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  sr_bank_driver_if.slave  tgt,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out
);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TMAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  sr_drv_state_t       state_r, state_s;
  logic [WIDTH-1:0]    tgt_r, tgt_s, s_r, s_s, r_r, r_s;
  logic [WIDTH-1:0]    set_mask_s, rst_mask_s;
  logic [2*SR_MAX_W-1:0] exc_s;
  logic [RW-1:0]       retries_r, retries_s;
  logic                busy_r, busy_s, done_r, done_s, err_r, err_s;
  logic                accept_s, match_s, tmr_load_s, tmr_tc_s;
  logic [TW-1:0]       tmr_val_s;

  assign tgt.tgt_ready = (state_r == ST_IDLE) && !rst;
  assign accept_s      = tgt.tgt_valid && tgt.tgt_ready;
  assign exc_s         = sr_excite(SR_MAX_W'(tgt_r), SR_MAX_W'(q_in));
  assign set_mask_s    = exc_s[SR_MAX_W +: WIDTH];
  assign rst_mask_s    = exc_s[0 +: WIDTH];
  assign match_s       = (q_in === tgt_r);

  if (WIDTH < SR_MAX_W) begin : g_pad
    logic [2*(SR_MAX_W-WIDTH)-1:0] exc_unused;
    assign exc_unused = {exc_s[2*SR_MAX_W-1 -: SR_MAX_W-WIDTH], exc_s[SR_MAX_W-1 -: SR_MAX_W-WIDTH]};
  end

  sr_phase_timer #(.MAX_CNT(TMAX), .CW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .tc       (tmr_tc_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   if (accept_s) state_s = ST_LOAD; else state_s = ST_IDLE;
      ST_LOAD:   if ((set_mask_s | rst_mask_s) == {WIDTH{1'b0}}) state_s = ST_CHECK;
                 else state_s = ST_PULSE;
      ST_PULSE:  if (tmr_tc_s) state_s = ST_SETTLE; else state_s = ST_PULSE;
      ST_SETTLE: if (tmr_tc_s) state_s = ST_CHECK; else state_s = ST_SETTLE;
      ST_CHECK:  if (match_s) state_s = ST_IDLE;
                 else if (retries_r < RW'(MAX_RETRY)) state_s = ST_LOAD;
                 else state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; masks are latched only on PULSE entry.
  always_comb begin
    tgt_s      = tgt_r;
    s_s        = {WIDTH{1'b0}};
    r_s        = {WIDTH{1'b0}};
    busy_s     = (state_s != ST_IDLE);
    done_s     = 1'b0;
    err_s      = 1'b0;
    retries_s  = retries_r;
    tmr_load_s = 1'b0;
    tmr_val_s  = TW'(PULSE_CYCLES - 1);
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          tgt_s     = tgt.tgt_data;
          retries_s = {RW{1'b0}};
        end else begin
          tgt_s     = tgt_r;
        end
      end
      ST_LOAD: begin
        if (state_s == ST_PULSE) begin
          s_s        = set_mask_s;
          r_s        = rst_mask_s;
          tmr_load_s = 1'b1;
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      ST_PULSE: begin
        if (state_s == ST_PULSE) begin
          s_s = s_r;
          r_s = r_r;
        end else begin
          tmr_load_s = 1'b1;
          tmr_val_s  = TW'(SETTLE_CYCLES - 1);
        end
      end
      ST_CHECK: begin
        if (match_s) begin
          done_s = 1'b1;
        end else if (retries_r < RW'(MAX_RETRY)) begin
          retries_s = retries_r + RW'(1);
        end else begin
          done_s = 1'b1;
          err_s  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_r     <= {WIDTH{1'b0}};
      s_r       <= {WIDTH{1'b0}};
      r_r       <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      retries_r <= {RW{1'b0}};
    end else begin
      tgt_r     <= tgt_s;
      s_r       <= s_s;
      r_r       <= r_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
      retries_r <= retries_s;
    end
  end

  assign s_out       = s_r;
  assign r_out       = r_r;
  assign tgt.busy    = busy_r;
  assign tgt.done    = done_r;
  assign tgt.err     = err_r;
  assign tgt.retries = retries_r;
endmodule

// File: tb/tb_sr_bank_driver.sv
// Bench for sr_bank_driver: an SR-FF bank model closes the loop, and a transaction-level
// predictor gives latency, error, retry count, first pulse and final bank state.
module tb_sr_bank_driver;
  localparam int W = 8, P = 2, S = 1, MR = 2, RW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_bank_driver_if #(.WIDTH(W), .RW(RW)) tgt_if ();
  logic [W-1:0] q_in, s_out, r_out;

  sr_bank_driver #(.WIDTH(W), .PULSE_CYCLES(P), .SETTLE_CYCLES(S), .MAX_RETRY(MR)) dut (
    .clk   (clk),
    .rst   (rst),
    .tgt   (tgt_if),
    .q_in  (q_in),
    .s_out (s_out),
    .r_out (r_out)
  );

  logic [W-1:0] bank, stuck0, preload_val;
  logic         preload = 1'b1;
  logic         force_x = 1'b0;

  always @(posedge clk) begin
    if (preload) bank <= preload_val;
    else         bank <= ((bank | s_out) & ~r_out) & ~stuck0;
  end
  assign q_in = force_x ? {1'bx, bank[W-2:0]} : bank;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Attempt-by-attempt prediction from the bank's starting state.
  task automatic predict(input logic [W-1:0] bank0, input logic [W-1:0] stk, input logic [W-1:0] t,
                         input logic xf, input logic xv,
                         output int lat, output logic perr, output int pret,
                         output logic [W-1:0] pbank, output logic [W-1:0] fs, output logic [W-1:0] fr,
                         output int npulse);
    logic [W-1:0] b, obs, sm, rm;
    b = bank0; lat = 0; perr = 1'b0; pret = 0; npulse = 0; fs = '0; fr = '0;
    for (int a = 0; a <= MR; a++) begin
      obs = xf ? {xv, b[W-2:0]} : b;
      for (int i = 0; i < W; i++) begin
        sm[i] = t[i] && !(obs[i] === 1'b1);
        rm[i] = !t[i] && !(obs[i] === 1'b0);
      end
      if (a == 0) begin fs = sm; fr = rm; end
      if ((sm | rm) == '0) lat += 2;
      else begin
        lat += P + S + 2;
        npulse += P;
        b = ((b | sm) & ~rm) & ~stk;
      end
      obs = xf ? {xv, b[W-2:0]} : b;
      if (obs === t) break;
      if (a == MR) perr = 1'b1;
      else pret++;
    end
    pbank = b;
  endtask

  task automatic load_bank(input logic [W-1:0] v);
    @(negedge clk); preload = 1'b1; preload_val = v;
    @(negedge clk); preload = 1'b0;
  endtask

  task automatic run_txn(input logic [W-1:0] t, input bit hold);
    int lat, pret, npulse, n, pulses;
    logic perr, got_done, seen, err_at_done;
    logic [W-1:0] pbank, fs, fr, os, orr;
    logic [RW-1:0] ret_at_done;
    predict(bank, stuck0, t, force_x, q_in[W-1], lat, perr, pret, pbank, fs, fr, npulse);
    @(posedge clk); #1;
    check_eq("ready_idle", tgt_if.tgt_ready, 1);
    tgt_if.tgt_valid = 1'b1; tgt_if.tgt_data = t;
    @(posedge clk); #1;
    if (hold) tgt_if.tgt_data = W'($urandom);
    else tgt_if.tgt_valid = 1'b0;
    n = 0; pulses = 0; got_done = 1'b0; seen = 1'b0; os = '0; orr = '0;
    err_at_done = 1'b0; ret_at_done = '0;
    while (!got_done && n < 100) begin
      @(posedge clk); #1; n++;
      check_eq("excl", s_out & r_out, 0);
      if ((s_out | r_out) != '0) begin
        pulses++;
        if (!seen) begin seen = 1'b1; os = s_out; orr = r_out; end
      end
      if (tgt_if.done) begin
        got_done = 1'b1; err_at_done = tgt_if.err; ret_at_done = tgt_if.retries;
        tgt_if.tgt_valid = 1'b0;
      end else begin
        check_eq("busy", tgt_if.busy, 1);
        check_eq("ready_busy", tgt_if.tgt_ready, 0);
        if (hold) tgt_if.tgt_data = W'($urandom);
      end
    end
    check_eq("done_seen", got_done, 1);
    check_eq("latency", n, lat);
    check_eq("err", err_at_done, perr);
    check_eq("retries", ret_at_done, pret);
    check_eq("first_s", os, fs);
    check_eq("first_r", orr, fr);
    check_eq("pulse_cycles", pulses, npulse);
    @(posedge clk); #1;
    check_eq("done_pulse", tgt_if.done, 0);
    check_eq("err_pulse", tgt_if.err, 0);
    check_eq("idle_busy", tgt_if.busy, 0);
    check_eq("bank", bank, pbank);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tgt_if.tgt_valid = 1'b0; tgt_if.tgt_data = '0;
    stuck0 = '0; preload_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_s", s_out, 0);
    check_eq("rst_r", r_out, 0);
    check_eq("rst_busy", tgt_if.busy, 0);
    check_eq("rst_done", tgt_if.done, 0);
    check_eq("rst_err", tgt_if.err, 0);
    check_eq("rst_retries", tgt_if.retries, 0);
    check_eq("rst_ready", tgt_if.tgt_ready, 0);
    preload = 1'b0; rst = 1'b0; #1;
    check_eq("ready_after_rst", tgt_if.tgt_ready, 1);

    run_txn(8'hA5, 1'b0);                  // set from zero
    run_txn(8'h3C, 1'b0);                  // mixed set/reset
    run_txn(8'h3C, 1'b0);                  // no-op

    stuck0 = 8'h01; load_bank(8'h00);      // stuck bit exhausts retries
    run_txn(8'h01, 1'b0);
    stuck0 = 8'h00;

    // Reset during PULSE aborts the transaction silently.
    load_bank(8'h00);
    @(posedge clk); #1;
    tgt_if.tgt_valid = 1'b1; tgt_if.tgt_data = 8'h5A;
    @(posedge clk); #1; tgt_if.tgt_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_pulse_s", s_out, 8'h5A);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_s", s_out, 0);
    check_eq("abort_r", r_out, 0);
    check_eq("abort_busy", tgt_if.busy, 0);
    check_eq("abort_done", tgt_if.done, 0);
    check_eq("abort_ready", tgt_if.tgt_ready, 0);
    rst = 1'b0; #1;
    check_eq("abort_ready_after", tgt_if.tgt_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("abort_no_done", tgt_if.done, 0);
    end
    run_txn(8'hFF, 1'b0);

    run_txn(8'h0F, 1'b1);                  // valid held with changing data while busy

    load_bank(8'h00);
    force_x = 1'b1;
    run_txn(8'h80, 1'b0);                  // unknown readback bit is never treated as correct
    force_x = 1'b0;

    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 3) == 0) load_bank(W'($urandom));
      run_txn(W'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
